// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the sub-word load/store sequencer: access sizes,
// FSM states and the default data-memory depth.
package mem_access_pkg;

    localparam int DEPTH_WORDS_DEF = 64;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_RMW_READ  = 2'd2,
        ST_RMW_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the pipeline request/response signals and the word-wide
// data-memory port handled by mem_access_ctrl.
interface mem_access_ctrl_if;

    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic        dm_memwrite;
    logic        dm_memread;
    logic [31:0] dm_read_data;

    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        addr_fault;

    // The controller side
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  dm_read_data,
        output dm_address, dm_write_data, dm_memwrite, dm_memread,
        output stall, resp_valid, resp_rdata, addr_fault
    );

    // The pipeline plus data memory side
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output dm_read_data,
        input  dm_address, dm_write_data, dm_memwrite, dm_memread,
        input  stall, resp_valid, resp_rdata, addr_fault
    );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Big-endian lane logic: extract/extend a byte or half from a memory word
// for loads, and merge store data into the read word for sub-word stores.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_wsrc;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];

        case (i_size)
            SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase

        // Replicate the store data so every lane sees its own copy
        case (i_size)
            SZ_BYTE: w_wsrc = {4{i_wdata[7:0]}};
            SZ_HALF: w_wsrc = {2{i_wdata[15:0]}};
            default: w_wsrc = i_wdata;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic w_en;

            assign w_en = (i_size == SZ_BYTE) ? (i_offset == LANE) :
                          (i_size == SZ_HALF) ? (i_offset[1] == LANE[1]) : 1'b1;
            assign o_merged[31-8*gi -: 8] = w_en ? w_wsrc[31-8*gi -: 8]
                                                 : i_rdata[31-8*gi -: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// Sub-word load/store sequencer in front of a word-only data memory with a
// one-cycle registered read; loads stall once, sub-word stores use read-modify-write.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    mem_access_ctrl_if.slave   mem_bus
);

    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    state_t      r_state;
    state_t      w_state_next;
    logic [29:0] r_word_addr;
    logic [1:0]  r_offset;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_wdata;
    logic [31:0] r_resp_rdata;

    logic        w_fault;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_fault = (mem_bus.req_size == SZ_RSVD)
                   | ((mem_bus.req_size == SZ_HALF) & mem_bus.req_addr[0])
                   | ((mem_bus.req_size == SZ_WORD) & (mem_bus.req_addr[1:0] != 2'b00))
                   | ({1'b0, mem_bus.req_addr} >= ADDR_LIMIT);

    mem_lane_align u_lane_align (
        .i_rdata     (mem_bus.dm_read_data),
        .i_offset    (r_offset),
        .i_size      (r_size),
        .i_signed    (r_signed),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_word_addr  <= '0;
            r_offset     <= '0;
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
        end else begin
            // Request inputs are only meaningful while IDLE; later states use the copy
            if (r_state == ST_IDLE && mem_bus.req_valid) begin
                r_word_addr <= mem_bus.req_addr[31:2];
                r_offset    <= mem_bus.req_addr[1:0];
                r_size      <= mem_bus.req_size;
                r_signed    <= mem_bus.req_signed;
                r_wdata     <= mem_bus.req_wdata;
            end
            if (r_state == ST_LOAD_WAIT) begin
                r_resp_rdata <= w_load_data;
            end
        end
    end

    always_comb begin
        w_state_next          = r_state;
        mem_bus.dm_address    = '0;
        mem_bus.dm_write_data = '0;
        mem_bus.dm_memwrite   = 1'b0;
        mem_bus.dm_memread    = 1'b0;
        mem_bus.stall         = 1'b0;
        mem_bus.resp_valid    = 1'b0;
        mem_bus.resp_rdata    = r_resp_rdata;
        mem_bus.addr_fault    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (mem_bus.req_valid) begin
                    if (w_fault) begin
                        mem_bus.addr_fault = 1'b1;
                    end else if (mem_bus.req_write && mem_bus.req_size == SZ_WORD) begin
                        mem_bus.dm_address    = {mem_bus.req_addr[31:2], 2'b00};
                        mem_bus.dm_write_data = mem_bus.req_wdata;
                        mem_bus.dm_memwrite   = 1'b1;
                    end else begin
                        mem_bus.dm_address = {mem_bus.req_addr[31:2], 2'b00};
                        mem_bus.dm_memread = 1'b1;
                        mem_bus.stall      = 1'b1;
                        w_state_next       = mem_bus.req_write ? ST_RMW_READ : ST_LOAD_WAIT;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                mem_bus.dm_address = {r_word_addr, 2'b00};
                mem_bus.resp_valid = 1'b1;
                mem_bus.resp_rdata = w_load_data;
                w_state_next       = ST_IDLE;
            end
            ST_RMW_READ: begin
                mem_bus.dm_address    = {r_word_addr, 2'b00};
                mem_bus.dm_write_data = w_merged;
                mem_bus.dm_memwrite   = 1'b1;
                w_state_next          = ST_RMW_WRITE;
            end
            ST_RMW_WRITE: begin
                // Bubble so EX/MEM cannot present a new op while the write settles
                mem_bus.stall = 1'b1;
                w_state_next  = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
